uncache_wbuf_bridge: RTL

//  Uncached CPU-to-bus bridge with a posted write buffer. Sits between the CPU

---
 rtl/uncache_wbuf_bridge.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uncache_wbuf_bridge.sv
// uncache_wbuf_bridge: uncached CPU-to-bus bridge with a posted store FIFO and ID-tagged single-beat loads.
// Define UNC_RAW_BYPASS_EN to let loads pass buffered stores to unrelated words.
module uncache_wbuf_bridge #(
   parameter int              ADDR_W     = 32,
   parameter int              DATA_W     = 32,
   parameter int              ID_W       = 4,
   parameter logic [ID_W-1:0] RD_ID      = ID_W'(1),
   parameter int              WBUF_DEPTH = 4,
   localparam int             STRB_W     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd_req,
   input  logic [STRB_W-1:0] cpu_wr_req,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_mem_stall,
   output logic [DATA_W-1:0] cpu_rd_data,
   output logic              wbuf_empty,
   output logic              ram_rd_req,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic              ram_arready,
   input  logic              ram_rvalid,
   input  logic [ID_W-1:0]   ram_rid,
   input  logic [DATA_W-1:0] ram_data_i,
   output logic              ram_wvalid,
   output logic              ram_wlast,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_data_o,
   output logic [STRB_W-1:0] ram_wstrb,
   input  logic              ram_wready,
   input  logic              ram_bvalid
);
   localparam int PTR_W = $clog2(WBUF_DEPTH);
   localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   w_state_t          r_wst, w_wst_nxt;
   r_state_t          r_rst, w_rst_nxt;
   logic [ADDR_W-1:0] r_fa [WBUF_DEPTH];
   logic [DATA_W-1:0] r_fd [WBUF_DEPTH];
   logic [STRB_W-1:0] r_fs [WBUF_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_wr_held;
   logic              w_store, w_push, w_pop, w_ld, w_rd_done, w_issue_ok;

   // a store accepted while a paired load still stalls must not be enqueued again
   assign w_store   = (|cpu_wr_req) & ~r_wr_held;
   assign w_push    = w_store & (r_count < CNT_W'(WBUF_DEPTH));
   assign w_pop     = (r_wst == W_RESP) & ram_bvalid;
   assign w_ld      = cpu_rd_req & ~w_store;
   assign w_rd_done = (r_rst == R_DATA) & ram_rvalid & (ram_rid == RD_ID);

   assign wbuf_empty    = (r_count == '0) & (r_wst == W_IDLE);
   assign cpu_mem_stall = (w_store & ~w_push) | (cpu_rd_req & ~w_rd_done);
   assign cpu_rd_data   = w_rd_done ? ram_data_i : '0;
   assign ram_rd_req    = r_rst == R_ADDR;
   assign ram_rd_addr   = ram_rd_req ? cpu_addr_i : '0;
   assign ram_wvalid    = r_wst == W_DATA;
   assign ram_wlast     = ram_wvalid;
   assign ram_wr_addr   = ram_wvalid ? r_fa[r_rptr] : '0;
   assign ram_data_o    = ram_wvalid ? r_fd[r_rptr] : '0;
   assign ram_wstrb     = ram_wvalid ? r_fs[r_rptr] : '0;

`ifdef UNC_RAW_BYPASS_EN
   localparam int LSB = $clog2(STRB_W);
   logic w_hit;
   // the in-flight write stays at the FIFO head until bvalid, so it is covered here
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < WBUF_DEPTH; i++)
         if ((CNT_W'(PTR_W'(i) - r_rptr) < r_count) && (r_fa[i][ADDR_W-1:LSB] == cpu_addr_i[ADDR_W-1:LSB]))
            w_hit = 1'b1;
   end
   assign w_issue_ok = ~w_hit;
`else
   assign w_issue_ok = wbuf_empty;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            r_fa[i] <= '0;
            r_fd[i] <= '0;
            r_fs[i] <= '0;
         end
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_wr_held <= 1'b0;
         r_wst     <= W_IDLE;
         r_rst     <= R_IDLE;
      end else begin
         if (w_push) begin
            r_fa[r_wptr] <= cpu_addr_i;
            r_fd[r_wptr] <= cpu_wr_data;
            r_fs[r_wptr] <= cpu_wr_req;
            r_wptr       <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         r_wr_held <= cpu_mem_stall & (r_wr_held | w_push);
         r_wst     <= w_wst_nxt;
         r_rst     <= w_rst_nxt;
      end
   end

   always_comb begin
      w_wst_nxt = r_wst;
      unique case (r_wst)
         W_IDLE:  w_wst_nxt = (r_count != '0) ? W_DATA : W_IDLE;
         W_DATA:  w_wst_nxt = ram_wready ? W_RESP : W_DATA;
         W_RESP:  w_wst_nxt = ram_bvalid ? W_IDLE : W_RESP;
         default: w_wst_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rst_nxt = r_rst;
      unique case (r_rst)
         R_IDLE:  w_rst_nxt = (w_ld & w_issue_ok) ? R_ADDR : R_IDLE;
         R_ADDR:  w_rst_nxt = ram_arready ? R_DATA : R_ADDR;
         R_DATA:  w_rst_nxt = w_rd_done ? R_IDLE : R_DATA;
         default: w_rst_nxt = R_IDLE;
      endcase
   end
endmodule
